// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction fetch with slot queue, redirect flush and stale-response drop
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic        ImemRValid,
  input  logic [31:0] ImemRData,
  input  logic        StallF,
  input  logic        BranchTakenE,
  input  logic [31:0] BranchTargetE,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        InstrValidF
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, fill_idx;
  logic [CW-1:0]    count_q, count_d, outstanding_q, outstanding_d, drop_q, drop_d;
  logic [31:0]      pc_q [DEPTH];
  logic [31:0]      pc_d [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      instr_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic             hs, fill, drop_resp, pop, empty;
  always_comb begin
    empty       = count_q == '0;
    ImemReq     = reset && count_q < CW'(DEPTH) && !BranchTakenE;
    ImemAddr    = fetch_pc_q;
    InstrValidF = reset && !empty && filled_q[head_q];
    PCF         = !reset ? RESET_PC : empty ? fetch_pc_q : pc_q[head_q];
    InstrF      = (!reset || empty) ? '0 : instr_q[head_q];
    PCPlus4F    = PCF + 32'd4;
    hs          = ImemReq && ImemReady;
    drop_resp   = ImemRValid && drop_q != '0;
    fill        = ImemRValid && drop_q == '0 && outstanding_q != '0;
    pop         = InstrValidF && !StallF;
    // filled slots form a prefix of the allocated run, so the oldest unfilled one follows it
    fill_idx      = head_q + PW'(count_q - outstanding_q);
    fetch_pc_d    = hs ? fetch_pc_q + 32'd4 : fetch_pc_q;
    head_d        = head_q + PW'(pop);
    tail_d        = tail_q + PW'(hs);
    count_d       = count_q + CW'(hs) - CW'(pop);
    outstanding_d = outstanding_q + CW'(hs) - CW'(fill);
    drop_d        = drop_q - CW'(drop_resp);
    pc_d          = pc_q;
    instr_d       = instr_q;
    filled_d      = filled_q;
    if (hs) begin
      pc_d[tail_q]     = fetch_pc_q;
      instr_d[tail_q]  = '0;
      filled_d[tail_q] = 1'b0;
    end
    if (fill) begin
      instr_d[fill_idx]  = ImemRData;
      filled_d[fill_idx] = 1'b1;
    end
    if (pop) filled_d[head_q] = 1'b0;
    if (BranchTakenE) begin
      fetch_pc_d    = BranchTargetE;
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
      outstanding_d = '0;
      filled_d      = '0;
      drop_d        = drop_q + outstanding_q - CW'(drop_resp) - CW'(fill);
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      filled_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      filled_q      <= filled_d;
    end
  end
  always_ff @(posedge clk) begin
    pc_q    <= pc_d;
    instr_q <= instr_d;
  end
  // a response nobody is waiting for is a memory-side protocol violation
  assert property (@(posedge clk) disable iff (!reset)
    !(ImemRValid && drop_q == '0 && outstanding_q == '0));
endmodule
